// File: rtl/l2_bank_pkg.sv
// rtl/l2_bank_pkg.sv - shared types and sizing helpers for the L2 bank memory adapter
package l2_bank_pkg;

  localparam int ID_W               = 16;
  localparam int DEF_BE_WIDTH       = 8;
  localparam int DEF_MEM_ADDR_WIDTH = 12;
  localparam int ADDR_LSB           = $clog2(DEF_BE_WIDTH);
  localparam int BANK_BYTES         = 2 ** (DEF_MEM_ADDR_WIDTH + ADDR_LSB);

  // One in-flight response slot, travelling alongside the SRAM read.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            is_read;
    logic            err;
  } resp_pipe_t;

  // Number of low byte-offset bits covered by one bank.
  function automatic int range_bits(input int mem_aw, input int be_w);
    return mem_aw + $clog2(be_w);
  endfunction

endpackage

// File: rtl/l2_bank_id_pipe.sv
// rtl/l2_bank_id_pipe.sv - fixed-depth shift register of response slots
module l2_bank_id_pipe
  import l2_bank_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  resp_pipe_t i_entry,
  output resp_pipe_t o_entry
);

  resp_pipe_t r_stage [DEPTH];

  // Shift one slot per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_entry = r_stage[DEPTH-1];

endmodule

// File: rtl/l2_bank_mem_adapter.sv
// rtl/l2_bank_mem_adapter.sv - drives one SRAM bank from the L2 req/gnt stream and returns responses
module l2_bank_mem_adapter
  import l2_bank_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    BE_WIDTH       = DATA_WIDTH / 8,
  parameter int                    ID_WIDTH       = ID_W,
  parameter int                    MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1C00_0000,
  parameter int                    READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  input  logic [ADDR_WIDTH-1:0]     data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  input  logic [ID_WIDTH-1:0]       data_ID_i,
  output logic                      data_gnt_o,
  output logic                      data_r_valid_o,
  output logic [ID_WIDTH-1:0]       data_r_ID_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic                      data_r_opc_o,
  input  logic                      stall_i,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int LP_ADDR_LSB   = $clog2(BE_WIDTH);
  localparam int LP_RANGE_BITS = range_bits(MEM_ADDR_WIDTH, BE_WIDTH);

  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_in_range;
  logic                  w_gnt;
  logic                  w_accept;
  logic                  w_unused_lsb;
  resp_pipe_t            w_stage_in;
  resp_pipe_t            w_stage_out;

  // Offset into the bank; addresses below the base wrap to huge values and fail the range test.
  assign w_offset     = data_add_i - BASE_ADDR;
  assign w_in_range   = ~|w_offset[ADDR_WIDTH-1:LP_RANGE_BITS];
  assign w_unused_lsb = ^w_offset[LP_ADDR_LSB-1:0];

  assign w_gnt      = data_req_i & ~stall_i & ~rst;
  assign w_accept   = data_req_i & w_gnt;
  assign data_gnt_o = w_gnt;

  // Out-of-range requests are granted but never touch the SRAM.
  assign mem_csn_o   = ~(w_accept & w_in_range);
  assign mem_wen_o   = data_wen_i;
  assign mem_add_o   = w_offset[LP_ADDR_LSB +: MEM_ADDR_WIDTH];
  assign mem_wdata_o = data_wdata_i;
  assign mem_be_o    = data_be_i;

  // Build the response slot for this cycle; idle cycles enter as all-zero bubbles.
  always_comb begin
    w_stage_in = '0;
    if (w_accept) begin
      w_stage_in.vld     = 1'b1;
      w_stage_in.id      = data_ID_i;
      w_stage_in.is_read = data_wen_i;
      w_stage_in.err     = ~w_in_range;
    end
  end

  l2_bank_id_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_id_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_entry (w_stage_in),
    .o_entry (w_stage_out)
  );

  // The last slot lines up with the SRAM output; only clean reads expose the macro's data.
  assign data_r_valid_o = w_stage_out.vld;
  assign data_r_ID_o    = w_stage_out.id;
  assign data_r_opc_o   = w_stage_out.err;
  assign data_r_rdata_o = (w_stage_out.is_read & ~w_stage_out.err) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_l2_bank_mem_adapter.sv
// tb/tb_l2_bank_mem_adapter.sv - directed self-checking bench for l2_bank_mem_adapter
module tb_l2_bank_mem_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req_i;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [63:0] data_wdata_i;
  logic [7:0]  data_be_i;
  logic [15:0] data_ID_i;
  logic        data_gnt_o;
  logic        data_r_valid_o;
  logic [15:0] data_r_ID_o;
  logic [63:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic        stall_i;
  logic        mem_csn_o;
  logic        mem_wen_o;
  logic [11:0] mem_add_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic [63:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_bank_mem_adapter #(
    .READ_LATENCY (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_ID_i      (data_ID_i),
    .data_gnt_o     (data_gnt_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_ID_o    (data_r_ID_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .stall_i        (stall_i),
    .mem_csn_o      (mem_csn_o),
    .mem_wen_o      (mem_wen_o),
    .mem_add_o      (mem_add_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_be_o       (mem_be_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // SRAM model: active-low csn/wen, byte-enabled writes, two-cycle read latency.
  logic [63:0] sram [4096];
  logic [63:0] rd_s1;

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = 64'h1111_0000_0000_0000 + 64'(i);
    rd_s1       = '0;
    mem_rdata_i = '0;
  end

  always @(posedge clk) begin
    if (!mem_csn_o && !mem_wen_o) begin
      for (int b = 0; b < 8; b++)
        if (mem_be_o[b]) sram[mem_add_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    end
    if (!mem_csn_o && mem_wen_o) rd_s1 <= sram[mem_add_o];
    mem_rdata_i <= rd_s1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic req, input logic wen, input logic [31:0] add, input logic [15:0] id);
    data_req_i = req;
    data_wen_i = wen;
    data_add_i = add;
    data_ID_i  = id;
    #1;
  endtask

  function automatic logic [63:0] exp_word(input int idx);
    return (idx == 2) ? 64'hDEAD_BEEF_0123_4567 : 64'h1111_0000_0000_0000 + 64'(idx);
  endfunction

  initial begin
    rst          = 1'b1;
    stall_i      = 1'b0;
    data_wdata_i = 64'hDEAD_BEEF_0123_4567;
    data_be_i    = 8'hFF;
    drive(1'b1, 1'b1, 32'h1C00_0000, 16'h0001);

    // reset with request pending
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", 64'(data_gnt_o), 64'd0);
      check("rst_csn", 64'(mem_csn_o), 64'd1);
      check("rst_rvalid", 64'(data_r_valid_o), 64'd0);
    end
    rst = 1'b0;
    #1;
    check("release_gnt", 64'(data_gnt_o), 64'd1);
    drive(1'b0, 1'b1, 32'h1C00_0000, 16'h0001);
    tick();
    tick();

    // write to 0x1C00_0010
    drive(1'b1, 1'b0, 32'h1C00_0010, 16'h0001);
    check("wr_gnt", 64'(data_gnt_o), 64'd1);
    check("wr_csn", 64'(mem_csn_o), 64'd0);
    check("wr_wen", 64'(mem_wen_o), 64'd0);
    check("wr_add", 64'(mem_add_o), 64'd2);
    tick();
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    check("wr_t1_rvalid", 64'(data_r_valid_o), 64'd0);
    tick();
    check("wr_t2_rvalid", 64'(data_r_valid_o), 64'd1);
    check("wr_t2_id", 64'(data_r_ID_o), 64'h0001);
    check("wr_t2_opc", 64'(data_r_opc_o), 64'd0);
    check("wr_t2_rdata", data_r_rdata_o, 64'd0);
    tick();
    check("wr_t3_rvalid", 64'(data_r_valid_o), 64'd0);

    // read it back with ID 0x0004
    drive(1'b1, 1'b1, 32'h1C00_0010, 16'h0004);
    check("rd_csn", 64'(mem_csn_o), 64'd0);
    check("rd_wen", 64'(mem_wen_o), 64'd1);
    check("rd_add", 64'(mem_add_o), 64'd2);
    tick();
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    check("rd_t1_rvalid", 64'(data_r_valid_o), 64'd0);
    tick();
    check("rd_t2_rvalid", 64'(data_r_valid_o), 64'd1);
    check("rd_t2_id", 64'(data_r_ID_o), 64'h0004);
    check("rd_t2_rdata", data_r_rdata_o, 64'hDEAD_BEEF_0123_4567);
    check("rd_t2_opc", 64'(data_r_opc_o), 64'd0);
    tick();

    // eight back-to-back reads of words 0..7
    for (int c = 0; c < 10; c++) begin
      if (c < 8) drive(1'b1, 1'b1, 32'h1C00_0000 + 32'(c * 8), 16'(1 << c));
      else       drive(1'b0, 1'b1, 32'h0, 16'h0);
      if (c >= 2) begin
        check("stream_rvalid", 64'(data_r_valid_o), 64'd1);
        check("stream_id", 64'(data_r_ID_o), 64'(1 << (c - 2)));
        check("stream_rdata", data_r_rdata_o, exp_word(c - 2));
      end else begin
        check("stream_pre_rvalid", 64'(data_r_valid_o), 64'd0);
      end
      tick();
    end
    check("stream_post_rvalid", 64'(data_r_valid_o), 64'd0);

    // last in-range word
    drive(1'b1, 1'b1, 32'h1C00_7FF8, 16'h0002);
    check("top_word_csn", 64'(mem_csn_o), 64'd0);
    check("top_word_add", 64'(mem_add_o), 64'hFFF);
    drive(1'b0, 1'b1, 32'h0, 16'h0);

    // out of range: exactly one bank above base, and one word below base
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, (k == 0) ? 32'h1C00_8000 : 32'h1BFF_FFF8, 16'h0010);
      check("oor_gnt", 64'(data_gnt_o), 64'd1);
      check("oor_csn", 64'(mem_csn_o), 64'd1);
      tick();
      drive(1'b0, 1'b1, 32'h0, 16'h0);
      tick();
      check("oor_rvalid", 64'(data_r_valid_o), 64'd1);
      check("oor_id", 64'(data_r_ID_o), 64'h0010);
      check("oor_opc", 64'(data_r_opc_o), 64'd1);
      check("oor_rdata", data_r_rdata_o, 64'd0);
      tick();
    end

    // stall while a read of word 3 is in flight
    drive(1'b1, 1'b1, 32'h1C00_0018, 16'h0100);
    tick();
    stall_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b1, 32'h1C00_0020, 16'h0200);
      check("stall_gnt", 64'(data_gnt_o), 64'd0);
      check("stall_csn", 64'(mem_csn_o), 64'd1);
      if (j == 1) begin
        check("stall_inflight_rvalid", 64'(data_r_valid_o), 64'd1);
        check("stall_inflight_id", 64'(data_r_ID_o), 64'h0100);
        check("stall_inflight_rdata", data_r_rdata_o, exp_word(3));
      end else begin
        check("stall_idle_rvalid", 64'(data_r_valid_o), 64'd0);
      end
      tick();
    end
    stall_i = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    tick();

    // reset the cycle after an accepted read
    drive(1'b1, 1'b1, 32'h1C00_0008, 16'h0040);
    check("rstmid_gnt", 64'(data_gnt_o), 64'd1);
    tick();
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_rvalid_t2", 64'(data_r_valid_o), 64'd0);
    tick();
    check("rstmid_rvalid_t3", 64'(data_r_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
